// File: rtl/mem_seq_ctrl.sv
// Byte-wide memory port sequencer: issues one 16-bit read or write as address/data
// byte transfers, waits for completion with a timeout, and reports one-hot state.
module mem_seq_ctrl #(
  parameter int RESET_CYCLES = 16,
  parameter int WAIT_TIMEOUT = 1024,
  parameter int DONE_HOLD    = 50_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_rd,
  input  logic        start_wr,
  input  logic [23:0] addr,
  input  logic [15:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] rd_data,
  output logic [12:0] state,
  output logic        bus_cs,
  output logic        bus_rw,
  output logic        bus_valid,
  output logic [7:0]  bus_dout,
  input  logic        bus_ready,
  input  logic [7:0]  bus_din,
  input  logic        bus_din_valid,
  input  logic        bus_wr_done
);

  typedef enum logic [12:0] {
    S_RESET   = 13'h0001,
    S_IDLE    = 13'h0002,
    S_RD0     = 13'h0004,
    S_RD1     = 13'h0008,
    S_RD2     = 13'h0010,
    S_RD_WAIT = 13'h0020,
    S_RD_DONE = 13'h0040,
    S_WR0     = 13'h0080,
    S_WR1     = 13'h0100,
    S_WR2     = 13'h0200,
    S_WR3     = 13'h0400,
    S_WR4     = 13'h0800,
    S_WR_WAIT = 13'h1000
  } state_t;

  localparam logic [31:0] RST_LAST  = 32'(RESET_CYCLES - 1);
  localparam logic [31:0] TMO_LAST  = 32'(WAIT_TIMEOUT - 1);
  localparam logic [31:0] HOLD_LAST = 32'(DONE_HOLD - 1);

  state_t      cur, nxt;
  logic [31:0] cnt;
  logic [23:0] addr_q;
  logic [15:0] data_q;
  logic [15:0] rd_q;
  logic [7:0]  lo_save;
  logic        have_lo;
  logic        done_q, err_q;
  logic        accept_rd, accept_wr, rd_complete, wr_complete, timeout;
  logic [7:0]  dout_c;

  // One shared cycle counter serves RESET, the WAIT timeout and the READ_DONE hold;
  // it restarts from zero on every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur <= S_RESET;
      cnt <= '0;
    end else begin
      cur <= nxt;
      cnt <= (nxt != cur) ? '0 : cnt + 32'd1;
    end
  end

  always_comb begin
    nxt         = cur;
    accept_rd   = 1'b0;
    accept_wr   = 1'b0;
    rd_complete = 1'b0;
    wr_complete = 1'b0;
    timeout     = 1'b0;
    unique case (cur)
      S_RESET: if (cnt == RST_LAST) nxt = S_IDLE;
      S_IDLE, S_RD_DONE: begin
        if (start_rd) begin
          accept_rd = 1'b1;
          nxt       = S_RD0;
        end else if (start_wr) begin
          accept_wr = 1'b1;
          nxt       = S_WR0;
        end else if (cur == S_RD_DONE && cnt == HOLD_LAST) begin
          nxt = S_IDLE;
        end
      end
      S_RD0: if (bus_ready) nxt = S_RD1;
      S_RD1: if (bus_ready) nxt = S_RD2;
      S_RD2: if (bus_ready) nxt = S_RD_WAIT;
      // Completion is tested first so it wins over a timeout on the same cycle.
      S_RD_WAIT: begin
        if (bus_din_valid && have_lo) begin
          rd_complete = 1'b1;
          nxt         = S_RD_DONE;
        end else if (cnt == TMO_LAST) begin
          timeout = 1'b1;
          nxt     = S_IDLE;
        end
      end
      S_WR0: if (bus_ready) nxt = S_WR1;
      S_WR1: if (bus_ready) nxt = S_WR2;
      S_WR2: if (bus_ready) nxt = S_WR3;
      S_WR3: if (bus_ready) nxt = S_WR4;
      S_WR4: if (bus_ready) nxt = S_WR_WAIT;
      S_WR_WAIT: begin
        if (bus_wr_done) begin
          wr_complete = 1'b1;
          nxt         = S_IDLE;
        end else if (cnt == TMO_LAST) begin
          timeout = 1'b1;
          nxt     = S_IDLE;
        end
      end
      default: nxt = S_RESET;
    endcase
  end

  // The low read byte is visible as soon as it arrives; lo_save lets a timeout
  // put the previous value back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      data_q  <= '0;
      rd_q    <= '0;
      lo_save <= '0;
      have_lo <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= rd_complete | wr_complete;
      if (accept_rd || accept_wr) begin
        addr_q <= addr;
        data_q <= wr_data;
        err_q  <= 1'b0;
      end else if (timeout) begin
        err_q <= 1'b1;
      end
      if (cur == S_RD_WAIT && bus_din_valid && !have_lo && !timeout) begin
        lo_save   <= rd_q[7:0];
        rd_q[7:0] <= bus_din;
        have_lo   <= 1'b1;
      end
      if (rd_complete) begin
        rd_q[15:8] <= bus_din;
        have_lo    <= 1'b0;
      end
      if (timeout) begin
        have_lo <= 1'b0;
        if (have_lo) rd_q[7:0] <= lo_save;
      end
    end
  end

  always_comb begin
    dout_c = 8'h00;
    unique case (cur)
      S_RD0, S_WR0: dout_c = addr_q[23:16];
      S_RD1, S_WR1: dout_c = addr_q[15:8];
      S_RD2, S_WR2: dout_c = addr_q[7:0];
      S_WR3:        dout_c = data_q[7:0];
      S_WR4:        dout_c = data_q[15:8];
      default:      dout_c = 8'h00;
    endcase
  end

  assign state     = cur;
  assign busy      = ~(cur[1] | cur[6]);
  assign bus_valid = (|cur[4:2]) | (|cur[11:7]);
  assign bus_cs    = (|cur[5:2]) | (|cur[12:7]);
  assign bus_rw    = |cur[5:2];
  assign bus_dout  = dout_c;
  assign done      = done_q;
  assign err       = err_q;
  assign rd_data   = rd_q;

endmodule

// File: tb/tb_mem_seq_ctrl.sv
// Self-checking bench for mem_seq_ctrl: directed scenarios plus randomized
// transactions checked against a transaction-level model of the sequencer.
module tb_mem_seq_ctrl;
  localparam int RST_CYC = 16;
  localparam int TMO     = 8;
  localparam int HOLD    = 12;

  logic        clk, rst_n, start_rd, start_wr;
  logic [23:0] addr;
  logic [15:0] wr_data, rd_data;
  logic        busy, done, err, bus_cs, bus_rw, bus_valid;
  logic [12:0] state;
  logic [7:0]  bus_dout, bus_din;
  logic        bus_ready, bus_din_valid, bus_wr_done;

  int          compared, mismatched;
  logic [15:0] expRd;
  logic        expErr;
  bit          inDone;

  mem_seq_ctrl #(.RESET_CYCLES(RST_CYC), .WAIT_TIMEOUT(TMO), .DONE_HOLD(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .start_rd(start_rd), .start_wr(start_wr),
    .addr(addr), .wr_data(wr_data), .busy(busy), .done(done), .err(err),
    .rd_data(rd_data), .state(state), .bus_cs(bus_cs), .bus_rw(bus_rw),
    .bus_valid(bus_valid), .bus_dout(bus_dout), .bus_ready(bus_ready),
    .bus_din(bus_din), .bus_din_valid(bus_din_valid), .bus_wr_done(bus_wr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyReset();
    rst_n = 1'b0; start_rd = 1'b0; start_wr = 1'b0;
    bus_ready = 1'b0; bus_din_valid = 1'b0; bus_wr_done = 1'b0;
    expRd = '0; expErr = 1'b0; inDone = 1'b0;
    #1;
    checkOutput("rst_state", 32'(state), 32'h1);
    checkOutput("rst_busy", 32'(busy), 32'h1);
    checkOutput("rst_done", 32'(done), 32'h0);
    checkOutput("rst_err", 32'(err), 32'h0);
    checkOutput("rst_rd_data", 32'(rd_data), 32'h0);
    checkOutput("rst_bus_cs", 32'(bus_cs), 32'h0);
    checkOutput("rst_bus_valid", 32'(bus_valid), 32'h0);
    checkOutput("rst_bus_dout", 32'(bus_dout), 32'h0);
    checkOutput("rst_bus_rw", 32'(bus_rw), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= RST_CYC; i++) begin
      start_rd = (i <= 10);
      start_wr = (i <= 10);
      @(negedge clk);
      if (i < RST_CYC) begin
        checkOutput("rst_hold_state", 32'(state), 32'h1);
        checkOutput("rst_hold_busy", 32'(busy), 32'h1);
      end else begin
        checkOutput("rst_exit_state", 32'(state), 32'h2);
        checkOutput("rst_exit_busy", 32'(busy), 32'h0);
      end
    end
    start_rd = 1'b0;
    start_wr = 1'b0;
  endtask

  task automatic idleGap(input int n);
    for (int i = 0; i < n; i++) begin
      checkOutput("idle_state", 32'(state), 32'h2);
      checkOutput("idle_busy", 32'(busy), 32'h0);
      checkOutput("idle_err", 32'(err), 32'(expErr));
      checkOutput("idle_rd_data", 32'(rd_data), 32'(expRd));
      checkOutput("idle_cs", 32'(bus_cs), 32'h0);
      @(negedge clk);
    end
  endtask

  task automatic acceptTxn(input bit rd, input bit wr, input logic [23:0] a, input logic [15:0] d);
    start_rd = rd; start_wr = wr; addr = a; wr_data = d;
    @(negedge clk);
    start_rd = 1'b0; start_wr = 1'b0;
    addr = 24'($urandom); wr_data = 16'($urandom);
    expErr = 1'b0;
    inDone = 1'b0;
    checkOutput("acc_state", 32'(state), rd ? 32'h4 : 32'h80);
    checkOutput("acc_valid", 32'(bus_valid), 32'h1);
    checkOutput("acc_cs", 32'(bus_cs), 32'h1);
    checkOutput("acc_busy", 32'(busy), 32'h1);
    checkOutput("acc_done", 32'(done), 32'h0);
    checkOutput("acc_err", 32'(err), 32'h0);
    checkOutput("acc_rw", 32'(bus_rw), 32'(rd));
  endtask

  task automatic sendBytes(input bit rd, input logic [23:0] a, input logic [15:0] d,
                           input int stallMode, input int nSend);
    logic [7:0] b [5];
    int stall;
    b[0] = a[23:16]; b[1] = a[15:8]; b[2] = a[7:0]; b[3] = d[7:0]; b[4] = d[15:8];
    for (int i = 0; i < nSend; i++) begin
      stall = (stallMode == 0) ? 0 : (stallMode == 2) ? 3 : int'($urandom_range(0, 2));
      for (int s = 0; s <= stall; s++) begin
        checkOutput("send_state", 32'(state), 32'h1 << (rd ? 2 + i : 7 + i));
        checkOutput("send_valid", 32'(bus_valid), 32'h1);
        checkOutput("send_byte", 32'(bus_dout), 32'(b[i]));
        checkOutput("send_rw", 32'(bus_rw), 32'(rd));
        bus_ready = (s == stall);
        start_rd = 1'($urandom);
        start_wr = 1'($urandom);
        @(negedge clk);
      end
    end
    bus_ready = 1'($urandom);
    start_rd = 1'b0;
    start_wr = 1'b0;
  endtask

  task automatic readWait(input int nBytes, input int t0, input int t1,
                          input logic [7:0] lo, input logic [7:0] hi);
    int limit;
    limit = (nBytes == 2) ? t1 + 1 : TMO;
    for (int c = 0; c < limit; c++) begin
      checkOutput("rwait_state", 32'(state), 32'h20);
      checkOutput("rwait_valid", 32'(bus_valid), 32'h0);
      checkOutput("rwait_cs", 32'(bus_cs), 32'h1);
      checkOutput("rwait_done", 32'(done), 32'h0);
      bus_din_valid = (nBytes >= 1 && c == t0) || (nBytes == 2 && c == t1);
      bus_din = (nBytes >= 1 && c == t0) ? lo : (nBytes == 2 && c == t1) ? hi : 8'($urandom);
      start_rd = 1'($urandom);
      start_wr = 1'($urandom);
      @(negedge clk);
    end
    bus_din_valid = 1'b0;
    start_rd = 1'b0;
    start_wr = 1'b0;
    if (nBytes == 2) begin
      expRd = {hi, lo};
      checkOutput("rdone_state", 32'(state), 32'h40);
      checkOutput("rdone_done", 32'(done), 32'h1);
      checkOutput("rdone_rd_data", 32'(rd_data), 32'(expRd));
      checkOutput("rdone_busy", 32'(busy), 32'h0);
      checkOutput("rdone_cs", 32'(bus_cs), 32'h0);
      checkOutput("rdone_err", 32'(err), 32'h0);
      inDone = 1'b1;
    end else begin
      expErr = 1'b1;
      checkOutput("rtmo_state", 32'(state), 32'h2);
      checkOutput("rtmo_err", 32'(err), 32'h1);
      checkOutput("rtmo_done", 32'(done), 32'h0);
      checkOutput("rtmo_rd_data", 32'(rd_data), 32'(expRd));
    end
  endtask

  task automatic holdDone();
    for (int k = 2; k <= HOLD; k++) begin
      bus_din_valid = 1'($urandom);
      bus_din = 8'($urandom);
      @(negedge clk);
      checkOutput("hold_state", 32'(state), 32'h40);
      checkOutput("hold_done", 32'(done), 32'h0);
      checkOutput("hold_rd_data", 32'(rd_data), 32'(expRd));
    end
    bus_din_valid = 1'b0;
    @(negedge clk);
    checkOutput("hold_exit_state", 32'(state), 32'h2);
    inDone = 1'b0;
  endtask

  task automatic writeWait(input bit ok, input int t);
    int limit;
    limit = ok ? t + 1 : TMO;
    for (int c = 0; c < limit; c++) begin
      checkOutput("wwait_state", 32'(state), 32'h1000);
      checkOutput("wwait_valid", 32'(bus_valid), 32'h0);
      checkOutput("wwait_rw", 32'(bus_rw), 32'h0);
      checkOutput("wwait_done", 32'(done), 32'h0);
      bus_wr_done = ok && (c == t);
      bus_din_valid = 1'($urandom);
      bus_din = 8'($urandom);
      @(negedge clk);
    end
    bus_wr_done = 1'b0;
    bus_din_valid = 1'b0;
    inDone = 1'b0;
    checkOutput("wend_state", 32'(state), 32'h2);
    checkOutput("wend_rd_data", 32'(rd_data), 32'(expRd));
    if (ok) begin
      checkOutput("wdone_done", 32'(done), 32'h1);
      checkOutput("wdone_err", 32'(err), 32'h0);
      @(negedge clk);
      checkOutput("wdone_pulse_end", 32'(done), 32'h0);
    end else begin
      expErr = 1'b1;
      checkOutput("wtmo_err", 32'(err), 32'h1);
      checkOutput("wtmo_done", 32'(done), 32'h0);
    end
  endtask

  task automatic applyStimulus(input int n);
    bit rd, wr, ok;
    logic [23:0] a;
    logic [15:0] d;
    int t0, t1;
    for (int k = 0; k < n; k++) begin
      rd = 1'($urandom);
      wr = rd ? 1'($urandom) : 1'b1;
      ok = ($urandom_range(0, 3) != 0);
      a = 24'($urandom);
      d = 16'($urandom);
      if (!inDone && $urandom_range(0, 1) == 1) idleGap(int'($urandom_range(1, 3)));
      acceptTxn(rd, wr, a, d);
      sendBytes(rd, a, d, 1, rd ? 3 : 5);
      if (rd) begin
        if (ok) begin
          t0 = int'($urandom_range(0, TMO - 2));
          t1 = ($urandom_range(0, 3) == 0) ? TMO - 1 : int'($urandom_range(t0 + 1, TMO - 1));
          readWait(2, t0, t1, 8'($urandom), 8'($urandom));
          if ($urandom_range(0, 1) == 1) holdDone();
        end else begin
          readWait(int'($urandom_range(0, 1)), int'($urandom_range(0, TMO - 1)), 0,
                   8'($urandom), 8'($urandom));
        end
      end else begin
        writeWait(ok, int'($urandom_range(0, TMO - 1)));
      end
    end
  endtask

  initial begin
    compared = 0; mismatched = 0;
    rst_n = 1'b1; start_rd = 1'b0; start_wr = 1'b0; addr = '0; wr_data = '0;
    bus_ready = 1'b0; bus_din = '0; bus_din_valid = 1'b0; bus_wr_done = 1'b0;
    expRd = '0; expErr = 1'b0; inDone = 1'b0;
    #1;
    applyReset();

    acceptTxn(1'b1, 1'b0, 24'h123456, 16'h0000);
    sendBytes(1'b1, 24'h123456, 16'h0000, 0, 3);
    readWait(2, 0, 1, 8'hCD, 8'hAB);
    holdDone();

    acceptTxn(1'b0, 1'b1, 24'h000010, 16'hBEEF);
    sendBytes(1'b0, 24'h000010, 16'hBEEF, 2, 5);
    writeWait(1'b1, 2);

    acceptTxn(1'b1, 1'b0, 24'hABCDEF, 16'h0000);
    sendBytes(1'b1, 24'hABCDEF, 16'h0000, 1, 3);
    readWait(1, 3, 0, 8'h55, 8'h00);
    idleGap(2);

    acceptTxn(1'b1, 1'b1, 24'h00FF00, 16'h1234);
    sendBytes(1'b1, 24'h00FF00, 16'h1234, 0, 3);
    readWait(2, 2, TMO - 1, 8'h11, 8'h22);
    acceptTxn(1'b0, 1'b1, 24'h777777, 16'h5A5A);
    sendBytes(1'b0, 24'h777777, 16'h5A5A, 1, 5);
    writeWait(1'b0, 0);

    applyStimulus(40);

    if (inDone) holdDone();
    idleGap(1);
    acceptTxn(1'b0, 1'b1, 24'h0A0B0C, 16'hC0DE);
    sendBytes(1'b0, 24'h0A0B0C, 16'hC0DE, 0, 3);
    checkOutput("wst3_state", 32'(state), 32'h400);
    applyReset();
    idleGap(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
